mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_req_ctrl
// Description : Single-outstanding request controller in front of an SRAM
//               driver. Accepts read / write requests, runs the driver
//               handshake, and performs read-modify-write for partial byte
//               enables. Address and write data are held in registers for the
//               whole operation because the driver does not latch them.
// Ports       : clk, rst               clock / async active-high reset
//               req_*                  request side (valid/ready handshake)
//               resp_valid, resp_rdata completion pulse and read data
//               ram_enable*            driver command outputs
//               ram_addr, ram_data_in  driver address / write data (held)
//               ram_data_out           driver read data (combinational)
//               ram_read_ready         driver is in its read state
//               ram_write_finished     driver one-cycle write-done pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_ctrl #(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [20:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        ram_enable,
    output logic        ram_enable_read,
    output logic        ram_enable_write,
    output logic [20:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    input  logic        ram_read_ready,
    input  logic        ram_write_finished
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_HOLD  = 3'd2,
        S_RD_REL   = 3'd3,
        S_WR_ISSUE = 3'd4,
        S_WR_WAIT  = 3'd5,
        S_DRAIN    = 3'd6
    } state_t;

    localparam logic [3:0] c_rd_last    = 4'(READ_WAIT - 1);
    localparam logic [1:0] c_drain_last = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [20:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_write;
    logic        r_zero_pend;   // be=0 write accepted, response due next edge
    logic [3:0]  r_rd_cnt;      // consecutive cycles with ram_read_ready high
    logic [1:0]  r_drain_cnt;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        w_accept;
    logic        w_rd_phase;
    logic        w_sample;
    logic [31:0] w_merged;

    assign w_accept   = (r_state == S_IDLE) && !r_zero_pend && req_valid;
    assign w_rd_phase = (r_state == S_RD_REQ) || (r_state == S_RD_HOLD);
    assign w_sample   = w_rd_phase && ram_read_ready && (r_rd_cnt == c_rd_last);

    assign ram_addr    = r_addr;
    assign ram_data_in = r_wdata;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;

    // Enabled bytes come from the request, the rest from the old SRAM word.
    always_comb begin
        w_merged = ram_data_out;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        req_ready        = 1'b0;
        ram_enable       = 1'b0;
        ram_enable_read  = 1'b0;
        ram_enable_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !r_zero_pend;
                if (w_accept) begin
                    if (!req_write) begin
                        w_state_nxt = S_RD_REQ;
                    end else if (req_be == 4'hF) begin
                        w_state_nxt = S_WR_ISSUE;
                    end else if (req_be == 4'h0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                ram_enable      = 1'b1;
                ram_enable_read = 1'b1;
                if (ram_read_ready) begin
                    w_state_nxt = w_sample ? S_RD_REL : S_RD_HOLD;
                end
            end
            S_RD_HOLD: begin
                ram_enable      = 1'b1;
                ram_enable_read = 1'b1;
                if (!ram_read_ready) begin
                    w_state_nxt = S_RD_REQ;
                end else if (w_sample) begin
                    w_state_nxt = S_RD_REL;
                end
            end
            S_RD_REL: begin
                // Read command dropped for one cycle so the driver leaves its
                // read state before anything else is issued.
                ram_enable  = 1'b1;
                w_state_nxt = r_write ? S_WR_ISSUE : S_IDLE;
            end
            S_WR_ISSUE: begin
                ram_enable       = 1'b1;
                ram_enable_write = 1'b1;
                w_state_nxt      = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                ram_enable = 1'b1;
                if (ram_write_finished) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Gives a driver that kept running through reset time to
                // finish a write it had already started.
                if (r_drain_cnt == c_drain_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_DRAIN;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_write      <= 1'b0;
            r_zero_pend  <= 1'b0;
            r_rd_cnt     <= '0;
            r_drain_cnt  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;

            if (r_zero_pend) begin
                r_zero_pend  <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_rdata <= '0;
            end

            if (w_accept) begin
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_be        <= req_be;
                r_write     <= req_write;
                r_zero_pend <= req_write && (req_be == 4'h0);
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= '0;
            end

            if (w_rd_phase && ram_read_ready && !w_sample) begin
                r_rd_cnt <= r_rd_cnt + 4'd1;
            end else begin
                r_rd_cnt <= '0;
            end

            if (w_sample) begin
                if (r_write) begin
                    r_wdata <= w_merged;
                end else begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= ram_data_out;
                end
            end

            if ((r_state == S_WR_WAIT) && ram_write_finished) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_ctrl
// Description : Bench for mem_req_ctrl with an SRAM driver model, a
//               transaction-level reference model and directed plus random
//               request streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_ctrl;

    localparam int RW = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [20:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        ram_enable;
    logic        ram_enable_read;
    logic        ram_enable_write;
    logic [20:0] ram_addr;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic        ram_read_ready = 1'b0;
    logic        ram_write_finished = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mem_req_ctrl #(.READ_WAIT(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ram_enable(ram_enable), .ram_enable_read(ram_enable_read),
        .ram_enable_write(ram_enable_write), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_read_ready(ram_read_ready), .ram_write_finished(ram_write_finished)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i + 1) * 32'h9E37_79B9;
    endfunction

    function automatic int midx(input logic [20:0] a);
        return int'({a[20], a[4:0]});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM driver model (not reset) ----------------
    logic [31:0] sram [0:63];
    bit          sram_init = 1'b0;
    logic [1:0]  wf_cnt = 2'd0;

    assign ram_data_out = sram[midx(ram_addr)];

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
            sram_init <= 1'b1;
        end
        ram_write_finished <= 1'b0;
        if (wf_cnt != 2'd0) begin
            wf_cnt <= wf_cnt - 2'd1;
            if (wf_cnt == 2'd1) ram_write_finished <= 1'b1;
        end
        if (ram_enable && ram_enable_write) begin
            sram[midx(ram_addr)] <= ram_data_in;
            wf_cnt <= 2'd2;
        end
        ram_read_ready <= ram_enable && ram_enable_read;
    end

    // ---------------- transaction-level reference model ----------------
    logic [31:0] ref_mem [0:63];
    bit          ref_init = 1'b0;
    int          cyc = 0;
    int          m_resp_at = -1;
    int          m_free_at = 0;
    int          m_drain = 3;
    bit          m_ready = 1'b0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] m_resp_data = '0;

    always @(posedge clk or posedge rst) begin
        if (!ref_init) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (rst) begin
            m_drain = 3; m_ready = 1'b0; m_resp_at = -1;
            exp_valid = 1'b0; exp_rdata = '0;
        end else begin
            cyc++;
            if (m_drain > 0) begin
                m_drain--;
                m_ready = (m_drain == 0);
            end else if (m_ready) begin
                if (req_valid) begin
                    int idx, rl, fl;
                    idx = midx(req_addr);
                    m_resp_data = '0;
                    if (!req_write) begin
                        m_resp_data = ref_mem[idx]; rl = RW + 1; fl = RW + 2;
                    end else if (req_be == 4'hF) begin
                        ref_mem[idx] = req_wdata; rl = 4; fl = 4;
                    end else if (req_be == 4'h0) begin
                        rl = 1; fl = 1;
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) ref_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
                        rl = RW + 6; fl = RW + 6;
                    end
                    m_resp_at = cyc + rl;
                    m_free_at = cyc + fl;
                    m_ready = 1'b0;
                end
            end else if (cyc == m_free_at) begin
                m_ready = 1'b1;
            end
            exp_valid = (cyc == m_resp_at);
            if (exp_valid) exp_rdata = m_resp_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        chk("req_ready", req_ready, m_ready);
        chk("resp_valid", resp_valid, exp_valid);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("rd_wr_excl", ram_enable_read & ram_enable_write, 0);
        chk("wr_while_rd_ready", ram_enable_write & ram_read_ready, 0);
        if (rst || m_ready || m_drain > 0)
            chk("idle_enables", {ram_enable, ram_enable_read, ram_enable_write}, 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input logic w, input logic [20:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat, output logic [31:0] rd,
                          output int nwr, output int nen);
        int  guard;
        bit  got;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_in_time", guard < 50, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; nwr = 0; nen = 0; got = 1'b0; rd = 'x;
        while (!got && lat < 60) begin
            nwr += int'(ram_enable_write);
            nen += int'(ram_enable);
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
            end
        end
        chk("resp_in_time", got, 1);
    endtask

    task automatic run_stream(input int ncyc, input bit rnd, output int nresp);
        logic        dw [0:2];
        logic [20:0] da [0:2];
        logic [31:0] dd [0:2];
        int  k;
        bit  was_ready;
        dw[0] = 1'b0; da[0] = 21'h000010; dd[0] = 32'h0;
        dw[1] = 1'b1; da[1] = 21'h000011; dd[1] = 32'h55AA_55AA;
        dw[2] = 1'b0; da[2] = 21'h000011; dd[2] = 32'h0;
        k = 0; was_ready = 1'b0; nresp = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
            if (req_valid && was_ready) k++;
            if (!req_valid || was_ready) begin
                if (rnd) begin
                    req_valid = ($urandom_range(0, 3) != 0);
                    req_write = 1'($urandom_range(0, 1));
                    req_addr  = {1'($urandom_range(0, 1)), 15'd0, 5'($urandom_range(0, 31))};
                    req_wdata = $urandom;
                    case ($urandom_range(0, 3))
                        0:       req_be = 4'hF;
                        1:       req_be = 4'h0;
                        default: req_be = 4'($urandom_range(1, 14));
                    endcase
                end else if (k < 3) begin
                    req_valid = 1'b1; req_write = dw[k]; req_addr = da[k];
                    req_wdata = dd[k]; req_be = 4'hF;
                end else begin
                    req_valid = 1'b0;
                end
            end
            was_ready = req_ready;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, nwr, nen, nresp;
        logic [31:0] rd;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_enables", {ram_enable, ram_enable_read, ram_enable_write}, 0);
        #1 rst = 1'b0;
        @(negedge clk); chk("drain_1", req_ready, 0);
        @(negedge clk); chk("drain_2", req_ready, 0);
        @(negedge clk); chk("drain_3", req_ready, 1);

        // Full writes, then the read of a known word.
        do_req(1'b1, 21'h000010, 32'hDEAD_BEEF, 4'hF, lat, rd, nwr, nen);
        chk("wr_lat", lat, 4); chk("wr_rdata", rd, 0); chk("wr_cmd_cycles", nwr, 1);
        do_req(1'b1, 21'h100004, 32'h1234_5678, 4'hF, lat, rd, nwr, nen);
        chk("ext_wr_lat", lat, 4); chk("ext_wr_rdata", rd, 0); chk("ext_wr_cmd_cycles", nwr, 1);
        chk("extram_word", sram[36], 32'h1234_5678);
        do_req(1'b0, 21'h000010, 32'h0, 4'h0, lat, rd, nwr, nen);
        chk("rd_lat", lat, 2); chk("rd_data", rd, 32'hDEAD_BEEF); chk("rd_no_write", nwr, 0);
        chk("rd_rel_cmd", {ram_enable, ram_enable_read, ram_enable_write}, 3'b100);

        // Read-modify-write.
        do_req(1'b1, 21'h00000C, 32'hAABB_CCDD, 4'hF, lat, rd, nwr, nen);
        do_req(1'b1, 21'h00000C, 32'h1122_3344, 4'b0101, lat, rd, nwr, nen);
        chk("rmw_lat", lat, RW + 6); chk("rmw_rdata", rd, 0); chk("rmw_cmd_cycles", nwr, 1);
        do_req(1'b0, 21'h00000C, 32'h0, 4'h0, lat, rd, nwr, nen);
        chk("rmw_result", rd, 32'hAA22_CC44);

        // Write with no byte enables.
        do_req(1'b1, 21'h000003, 32'hFFFF_FFFF, 4'h0, lat, rd, nwr, nen);
        chk("be0_lat", lat, 1); chk("be0_enables", nen, 0); chk("be0_rdata", rd, 0);
        do_req(1'b0, 21'h000003, 32'h0, 4'h0, lat, rd, nwr, nen);
        chk("be0_untouched", rd, init_word(3));

        // Reset while waiting for write completion.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h000005;
        req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        for (int g = 0; g < 50 && !req_ready; g++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_issue_cmd", {ram_enable, ram_enable_write}, 2'b11);
        @(negedge clk);
        chk("wr_wait_cmd", {ram_enable, ram_enable_write}, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("abort_enables", {ram_enable, ram_enable_read, ram_enable_write}, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_ram_addr", 32'(ram_addr), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("abort_drain_1", req_ready, 0);
        @(negedge clk); chk("abort_drain_2", req_ready, 0);
        @(negedge clk); chk("abort_drain_3", req_ready, 1);
        do_req(1'b0, 21'h000005, 32'h0, 4'h0, lat, rd, nwr, nen);
        chk("post_abort_read", rd, 32'hCAFE_F00D);

        // Back-to-back read, write, read with valid held high.
        run_stream(40, 1'b0, nresp);
        chk("b2b_responses", nresp, 3);

        // Randomized traffic.
        run_stream(3000, 1'b1, nresp);

        repeat (20) @(negedge clk);
        for (int i = 0; i < 64; i++) chk("final_mem", sram[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
